srambank_arb2: RTL and testbench

- Two-port arbiter and sequencer in front of one 512x72 synchronous SRAM bank (srambank_128x4x72_6t122).
- Shares the bank between requester A and requester B using round-robin.
- Registers the winning command onto the bank's banksel/read/write/ADDRESS/wd pins, tracks each in-flight read, and returns the bank's dataout to the issuing port with a per-port valid.

---
 rtl/srambank_arb2_if.sv | 47 ++++
 rtl/srambank_arb2.sv | 116 +++++++++++
 tb/tb_srambank_arb2.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/srambank_arb2_if.sv
// Bus bundle for srambank_arb2: two requester ports plus the SRAM bank pins.
// The master side is the environment (requesters and bank), the slave side is the arbiter.
interface srambank_arb2_if #(
    parameter int AW = 9,
    parameter int DW = 72
);
    logic          a_req;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic          a_gnt;
    logic          a_rvalid;
    logic [DW-1:0] a_rdata;

    logic          b_req;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic          b_gnt;
    logic          b_rvalid;
    logic [DW-1:0] b_rdata;

    logic          sram_banksel;
    logic          sram_read;
    logic          sram_write;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wd;
    logic [DW-1:0] sram_dataout;

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  sram_banksel, sram_read, sram_write, sram_addr, sram_wd,
        output sram_dataout
    );

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_gnt, b_rvalid, b_rdata,
        output sram_banksel, sram_read, sram_write, sram_addr, sram_wd,
        input  sram_dataout
    );
endinterface

// File: rtl/srambank_arb2.sv
// Round-robin two-port arbiter and two-stage sequencer in front of one synchronous
// 512x72 SRAM bank; read data returns to the issuing port two cycles after grant.
module srambank_arb2 #(
    parameter int AW = 9,
    parameter int DW = 72
) (
    input  logic           clk,
    input  logic           reset_n,
    srambank_arb2_if.slave bus
);
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    logic          last_r;
    logic          s1_port_r;
    logic          s1_rd_r;
    logic          s2_port_r;
    logic          s2_rd_r;
    logic [DW-1:0] a_hold_r;
    logic [DW-1:0] b_hold_r;

    logic          gnt_a_s;
    logic          gnt_b_s;
    logic          any_gnt_s;
    logic          sel_we_s;
    logic [AW-1:0] sel_addr_s;
    logic [DW-1:0] sel_wdata_s;
    logic          a_valid_s;
    logic          b_valid_s;

    // Grant selection: lone requester wins outright, a tie goes to the port not granted last.
    always_comb begin
        gnt_a_s     = 1'b0;
        gnt_b_s     = 1'b0;
        gnt_a_s     = reset_n & bus.a_req & (~bus.b_req | (last_r == PORT_B));
        gnt_b_s     = reset_n & bus.b_req & (~bus.a_req | (last_r == PORT_A));
        any_gnt_s   = gnt_a_s | gnt_b_s;
        sel_we_s    = gnt_b_s ? bus.b_we    : bus.a_we;
        sel_addr_s  = gnt_b_s ? bus.b_addr  : bus.a_addr;
        sel_wdata_s = gnt_b_s ? bus.b_wdata : bus.a_wdata;
        bus.a_gnt   = gnt_a_s;
        bus.b_gnt   = gnt_b_s;
    end

    // Issue stage: register the winning command onto the bank pins and tag it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.sram_banksel <= 1'b0;
            bus.sram_read    <= 1'b0;
            bus.sram_write   <= 1'b0;
            bus.sram_addr    <= {AW{1'b0}};
            bus.sram_wd      <= {DW{1'b0}};
            s1_port_r        <= PORT_A;
            s1_rd_r          <= 1'b0;
            last_r           <= PORT_B;
        end else if (any_gnt_s) begin
            bus.sram_banksel <= 1'b1;
            bus.sram_write   <= sel_we_s;
            bus.sram_read    <= ~sel_we_s;
            bus.sram_addr    <= sel_addr_s;
            if (sel_we_s) begin
                bus.sram_wd <= sel_wdata_s;
            end else begin
                bus.sram_wd <= bus.sram_wd;
            end
            s1_port_r        <= gnt_b_s;
            s1_rd_r          <= ~sel_we_s;
            last_r           <= gnt_b_s;
        end else begin
            bus.sram_banksel <= 1'b0;
            bus.sram_read    <= 1'b0;
            bus.sram_write   <= 1'b0;
            s1_rd_r          <= 1'b0;
        end
    end

    // Response tag: follows the issue stage by one cycle, aligned with bank dataout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_rd_r   <= 1'b0;
            s2_port_r <= PORT_A;
        end else begin
            s2_rd_r   <= s1_rd_r;
            s2_port_r <= s1_port_r;
        end
    end

    // Response steering: valid port sees dataout directly, the other shows its last data.
    always_comb begin
        a_valid_s    = reset_n & s2_rd_r & (s2_port_r == PORT_A);
        b_valid_s    = reset_n & s2_rd_r & (s2_port_r == PORT_B);
        bus.a_rvalid = a_valid_s;
        bus.b_rvalid = b_valid_s;
        bus.a_rdata  = a_valid_s ? bus.sram_dataout : a_hold_r;
        bus.b_rdata  = b_valid_s ? bus.sram_dataout : b_hold_r;
    end

    // Per-port holding registers capture read data on each valid cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_hold_r <= {DW{1'b0}};
            b_hold_r <= {DW{1'b0}};
        end else begin
            if (a_valid_s) begin
                a_hold_r <= bus.sram_dataout;
            end else begin
                a_hold_r <= a_hold_r;
            end
            if (b_valid_s) begin
                b_hold_r <= bus.sram_dataout;
            end else begin
                b_hold_r <= b_hold_r;
            end
        end
    end
endmodule

// File: tb/tb_srambank_arb2.sv
// Directed self-checking bench for srambank_arb2 with a behavioural 512x72 synchronous bank.
module tb_srambank_arb2;
    localparam int AW = 9;
    localparam int DW = 72;

    logic clk;
    logic reset_n;
    int   vectors;
    int   miscompares;

    logic [DW-1:0] mem [512];
    logic [DW-1:0] pat5a;
    logic [DW-1:0] patabc;

    srambank_arb2_if #(.AW(AW), .DW(DW)) bus ();

    srambank_arb2 #(.AW(AW), .DW(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural bank: write and read both execute on the edge after the command is on the pins.
    always @(posedge clk) begin
        if (bus.sram_banksel) begin
            if (bus.sram_write) mem[bus.sram_addr] <= bus.sram_wd;
            if (bus.sram_read)  bus.sram_dataout   <= mem[bus.sram_addr];
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
    endtask

    task automatic drive_b(input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive_a(1'b1, 1'b0, 9'h000, 72'h0);
        drive_b(1'b1, 1'b0, 9'h000, 72'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus.a_gnt !== 1'b0 || bus.b_gnt !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_gnt: got a=%0b b=%0b want a=0 b=0", bus.a_gnt, bus.b_gnt);
        end
        vectors++;
        if (bus.sram_banksel !== 1'b0 || bus.sram_read !== 1'b0 || bus.sram_write !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_bank: got sel=%0b rd=%0b wr=%0b want 0 0 0", bus.sram_banksel, bus.sram_read, bus.sram_write);
        end
        vectors++;
        if (bus.a_rvalid !== 1'b0 || bus.b_rvalid !== 1'b0 || bus.a_rdata !== 72'h0 || bus.b_rdata !== 72'h0) begin
            miscompares++;
            $display("FAIL reset_resp: got av=%0b bv=%0b ad=%h bd=%h want 0 0 0 0", bus.a_rvalid, bus.b_rvalid, bus.a_rdata, bus.b_rdata);
        end
        next_cycle();
        reset_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.a_gnt !== 1'b1 || bus.b_gnt !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_first_tie: got a=%0b b=%0b want a=1 b=0", bus.a_gnt, bus.b_gnt);
        end
        next_cycle();
        drive_a(1'b0, 1'b0, 9'h000, 72'h0);
        drive_b(1'b0, 1'b0, 9'h000, 72'h0);
        repeat (3) next_cycle();
    endtask

    task automatic test_single_read();
        drive_a(1'b1, 1'b1, 9'h1FF, pat5a);
        @(negedge clk);
        vectors++;
        if (bus.a_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL single_wr_gnt: got %0b want 1", bus.a_gnt);
        end
        next_cycle();
        drive_a(1'b1, 1'b0, 9'h1FF, 72'h0);
        @(negedge clk);
        vectors++;
        if (bus.a_gnt !== 1'b1 || bus.sram_write !== 1'b1 || bus.sram_addr !== 9'h1FF || bus.sram_wd !== pat5a) begin
            miscompares++;
            $display("FAIL single_wr_issue: got gnt=%0b wr=%0b addr=%h wd=%h want 1 1 1ff %h",
                     bus.a_gnt, bus.sram_write, bus.sram_addr, bus.sram_wd, pat5a);
        end
        next_cycle();
        drive_a(1'b0, 1'b0, 9'h000, 72'h0);
        @(negedge clk);
        vectors++;
        if (bus.a_rvalid !== 1'b0 || bus.sram_read !== 1'b1 || bus.sram_write !== 1'b0) begin
            miscompares++;
            $display("FAIL single_rd_issue: got rvalid=%0b rd=%0b wr=%0b want 0 1 0", bus.a_rvalid, bus.sram_read, bus.sram_write);
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if (bus.a_rvalid !== 1'b1 || bus.a_rdata !== pat5a || bus.b_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_rd_resp: got av=%0b ad=%h bv=%0b want 1 %h 0", bus.a_rvalid, bus.a_rdata, bus.b_rvalid, pat5a);
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if (bus.a_rvalid !== 1'b0 || bus.a_rdata !== pat5a) begin
            miscompares++;
            $display("FAIL single_rd_hold: got av=%0b ad=%h want 0 %h", bus.a_rvalid, bus.a_rdata, pat5a);
        end
        repeat (2) next_cycle();
    endtask

    task automatic test_contention();
        logic exp_a;
        // A lone B read first so that A owns the first tie below.
        drive_b(1'b1, 1'b0, 9'h000, 72'h0);
        @(negedge clk);
        vectors++;
        if (bus.b_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL cont_prep_gnt: got %0b want 1", bus.b_gnt);
        end
        next_cycle();
        drive_b(1'b0, 1'b0, 9'h000, 72'h0);
        repeat (3) next_cycle();
        for (int k = 0; k < 8; k++) begin
            if (k < 6) begin
                drive_a(1'b1, 1'b0, 9'h1FF, 72'h0);
                drive_b(1'b1, 1'b0, 9'h000, 72'h0);
            end else begin
                drive_a(1'b0, 1'b0, 9'h000, 72'h0);
                drive_b(1'b0, 1'b0, 9'h000, 72'h0);
            end
            @(negedge clk);
            if (k < 6) begin
                exp_a = ((k % 2) == 0);
                vectors++;
                if (bus.a_gnt !== exp_a || bus.b_gnt !== ~exp_a) begin
                    miscompares++;
                    $display("FAIL cont_gnt[%0d]: got a=%0b b=%0b want a=%0b b=%0b", k, bus.a_gnt, bus.b_gnt, exp_a, ~exp_a);
                end
            end
            if (k >= 1 && k <= 6) begin
                vectors++;
                if (bus.sram_banksel !== 1'b1) begin
                    miscompares++;
                    $display("FAIL cont_banksel[%0d]: got %0b want 1", k, bus.sram_banksel);
                end
            end
            if (k >= 2) begin
                exp_a = ((k % 2) == 0);
                vectors++;
                if (bus.a_rvalid !== exp_a || bus.b_rvalid !== ~exp_a) begin
                    miscompares++;
                    $display("FAIL cont_rvalid[%0d]: got a=%0b b=%0b want a=%0b b=%0b", k, bus.a_rvalid, bus.b_rvalid, exp_a, ~exp_a);
                end
                vectors++;
                if (bus.a_rdata !== pat5a || bus.b_rdata !== 72'h0) begin
                    miscompares++;
                    $display("FAIL cont_rdata[%0d]: got a=%h b=%h want a=%h b=0", k, bus.a_rdata, bus.b_rdata, pat5a);
                end
            end
            next_cycle();
        end
        repeat (2) next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] addrs [4];
        logic          wes   [4];
        logic [DW-1:0] wds   [4];
        addrs[0] = 9'd3; wes[0] = 1'b1; wds[0] = 72'h0;
        addrs[1] = 9'd4; wes[1] = 1'b1; wds[1] = 72'h1;
        addrs[2] = 9'd4; wes[2] = 1'b0; wds[2] = 72'h0;
        addrs[3] = 9'd3; wes[3] = 1'b0; wds[3] = 72'h0;
        for (int k = 0; k < 7; k++) begin
            if (k < 4) drive_b(1'b1, wes[k], addrs[k], wds[k]);
            else       drive_b(1'b0, 1'b0, 9'h000, 72'h0);
            @(negedge clk);
            if (k < 4) begin
                vectors++;
                if (bus.b_gnt !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_gnt[%0d]: got %0b want 1", k, bus.b_gnt);
                end
            end
            vectors++;
            if (bus.sram_read === 1'b1 && bus.sram_write === 1'b1) begin
                miscompares++;
                $display("FAIL b2b_rdwr[%0d]: got rd=1 wr=1 want not both", k);
            end
            if (k == 4 || k == 5) begin
                vectors++;
                if (bus.b_rvalid !== 1'b1 || bus.b_rdata !== ((k == 4) ? 72'h1 : 72'h0) || bus.a_rvalid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_resp[%0d]: got bv=%0b bd=%h av=%0b want 1 %h 0",
                             k, bus.b_rvalid, bus.b_rdata, bus.a_rvalid, ((k == 4) ? 72'h1 : 72'h0));
                end
            end
            if (k == 6) begin
                vectors++;
                if (bus.b_rvalid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_tail: got bv=%0b want 0", bus.b_rvalid);
                end
            end
            next_cycle();
        end
        repeat (2) next_cycle();
    endtask

    task automatic test_lone();
        for (int k = 0; k < 8; k++) begin
            drive_b((k < 6) ? 1'b1 : 1'b0, 1'b0, 9'd4, 72'h0);
            drive_a((k == 4) ? 1'b1 : 1'b0, 1'b0, 9'h1FF, 72'h0);
            @(negedge clk);
            if (k < 4 || k == 5) begin
                vectors++;
                if (bus.b_gnt !== 1'b1 || bus.a_gnt !== 1'b0) begin
                    miscompares++;
                    $display("FAIL lone_gnt[%0d]: got a=%0b b=%0b want a=0 b=1", k, bus.a_gnt, bus.b_gnt);
                end
            end
            if (k == 4) begin
                vectors++;
                if (bus.a_gnt !== 1'b1 || bus.b_gnt !== 1'b0) begin
                    miscompares++;
                    $display("FAIL lone_rr: got a=%0b b=%0b want a=1 b=0", bus.a_gnt, bus.b_gnt);
                end
            end
            if (k == 6) begin
                vectors++;
                if (bus.a_rvalid !== 1'b1 || bus.a_rdata !== pat5a) begin
                    miscompares++;
                    $display("FAIL lone_a_resp: got av=%0b ad=%h want 1 %h", bus.a_rvalid, bus.a_rdata, pat5a);
                end
            end
            if (k == 7) begin
                vectors++;
                if (bus.b_rvalid !== 1'b1 || bus.b_rdata !== 72'h1) begin
                    miscompares++;
                    $display("FAIL lone_b_resp: got bv=%0b bd=%h want 1 1", bus.b_rvalid, bus.b_rdata);
                end
            end
            next_cycle();
        end
        repeat (2) next_cycle();
    endtask

    task automatic test_reset_midflight();
        drive_a(1'b1, 1'b1, 9'h010, patabc);
        next_cycle();
        drive_a(1'b0, 1'b0, 9'h000, 72'h0);
        repeat (3) next_cycle();
        drive_a(1'b1, 1'b0, 9'h010, 72'h0);
        @(negedge clk);
        vectors++;
        if (bus.a_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_rd_gnt: got %0b want 1", bus.a_gnt);
        end
        next_cycle();
        drive_a(1'b0, 1'b0, 9'h000, 72'h0);
        reset_n = 1'b0;
        next_cycle();
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++;
            if (bus.a_rvalid !== 1'b0 || bus.a_rdata !== 72'h0) begin
                miscompares++;
                $display("FAIL mid_discard[%0d]: got av=%0b ad=%h want 0 0", k, bus.a_rvalid, bus.a_rdata);
            end
            next_cycle();
        end
        drive_a(1'b1, 1'b0, 9'h010, 72'h0);
        next_cycle();
        drive_a(1'b0, 1'b0, 9'h000, 72'h0);
        next_cycle();
        @(negedge clk);
        vectors++;
        if (bus.a_rvalid !== 1'b1 || bus.a_rdata !== patabc) begin
            miscompares++;
            $display("FAIL mid_reread: got av=%0b ad=%h want 1 %h", bus.a_rvalid, bus.a_rdata, patabc);
        end
        repeat (2) next_cycle();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        pat5a       = {9{8'h5A}};
        patabc      = 72'hAB_CDEF_0123_4567_89AB;
        for (int i = 0; i < 512; i++) mem[i] = 72'h0;
        bus.sram_dataout = 72'h0;
        reset_n = 1'b0;
        drive_a(1'b0, 1'b0, 9'h000, 72'h0);
        drive_b(1'b0, 1'b0, 9'h000, 72'h0);
        test_reset();
        test_single_read();
        test_contention();
        test_back_to_back();
        test_lone();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
